// File: rtl/prog_loader_pkg.sv
// Shared types and widths for the serial program loader.
// Holds the FSM state set plus the default memory geometry.
package prog_loader_pkg;

  localparam int DEPTH_DEF  = 16;
  localparam int ADDR_W_DEF = 4;
  localparam int BYTE_W     = 8;
  localparam int WORD_W     = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_DATA,
    ST_WRITE,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The master is the host/memory side; the slave is the loader itself.
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);

  logic [BYTE_W-1:0] byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/prog_loader_word_assembler.sv
// Shifts accepted bytes into a 32-bit word, MSB-first, and keeps the
// running XOR of every byte shifted in since the last clear.
module word_assembler
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              sys_rst,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [WORD_W-1:0] word,
  output logic [BYTE_W-1:0] xor_sum
);

  // NOTE: non-blocking assignments for every register so all flops sample
  // their inputs from the same pre-edge values.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      word    <= '0;
      xor_sum <= '0;
    end else if (clr) begin
      word    <= '0;
      xor_sum <= '0;
    end else if (shift_en) begin
      word    <= {word[WORD_W-BYTE_W-1:0], byte_in};
      xor_sum <= xor_sum ^ byte_in;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Serial program loader: header byte N, 4*N data bytes, XOR checksum.
// Writes each assembled word to instruction memory and holds the CPU until a good load.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
)
(
  input  logic         clk,
  input  logic         sys_rst,
  input  logic         start,
  prog_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         load_done,
  output logic         load_err
);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   word_idx, last_addr;
  logic [ADDR_W:0]     n_words;
  logic [1:0]          byte_cnt;
  logic [WORD_W-1:0]   asm_word, last_wdata;
  logic [BYTE_W-1:0]   xor_sum;
  logic                clr, shift_en, latch_n, idx_inc;
  logic                byte_ready, mem_we;
  logic                hdr_bad, last_word;

  assign hdr_bad   = (bus.byte_in == '0) || (int'(bus.byte_in) > DEPTH);
  assign last_word = ({1'b0, word_idx} == (n_words - (ADDR_W+1)'(1)));

  // NOTE: every always_comb output gets a default first so no path leaves
  // a signal unassigned and infers a latch.
  always_comb begin
    state_nxt  = state;
    byte_ready = 1'b0;
    mem_we     = 1'b0;
    clr        = 1'b0;
    shift_en   = 1'b0;
    latch_n    = 1'b0;
    idx_inc    = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_nxt = ST_HDR;
          clr       = 1'b1;
        end
      end
      ST_HDR: begin
        byte_ready = 1'b1;
        if (bus.byte_valid) begin
          if (hdr_bad) begin
            state_nxt = ST_ERR;
          end else begin
            state_nxt = ST_DATA;
            latch_n   = 1'b1;
          end
        end
      end
      ST_DATA: begin
        byte_ready = 1'b1;
        if (bus.byte_valid) begin
          shift_en = 1'b1;
          if (byte_cnt == 2'd3) state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        mem_we = 1'b1;
        if (last_word) begin
          state_nxt = ST_CSUM;
        end else begin
          state_nxt = ST_DATA;
          idx_inc   = 1'b1;
        end
      end
      ST_CSUM: begin
        byte_ready = 1'b1;
        if (bus.byte_valid) state_nxt = (bus.byte_in == xor_sum) ? ST_DONE : ST_ERR;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= ST_IDLE;
      word_idx   <= '0;
      byte_cnt   <= '0;
      n_words    <= '0;
      last_addr  <= '0;
      last_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (clr) begin
        word_idx <= '0;
        byte_cnt <= '0;
      end
      if (latch_n)  n_words  <= (ADDR_W+1)'(bus.byte_in);
      if (shift_en) byte_cnt <= byte_cnt + 2'd1;
      if (idx_inc)  word_idx <= word_idx + ADDR_W'(1);
      // Remember the last write so the port holds steady outside WRITE.
      if (state == ST_WRITE) begin
        last_addr  <= word_idx;
        last_wdata <= asm_word;
      end
    end
  end

  word_assembler u_asm (
    .clk      (clk),
    .sys_rst  (sys_rst),
    .clr      (clr),
    .shift_en (shift_en),
    .byte_in  (bus.byte_in),
    .word     (asm_word),
    .xor_sum  (xor_sum)
  );

  assign bus.byte_ready = byte_ready;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = (state == ST_WRITE) ? word_idx : last_addr;
  assign bus.mem_wdata  = (state == ST_WRITE) ? asm_word : last_wdata;

  assign load_done = (state == ST_DONE);
  assign load_err  = (state == ST_ERR);
  assign cpu_hold  = (state != ST_DONE);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a session-level model predicts every memory
// write and the final status; a per-cycle monitor checks the write port.
module tb_prog_loader;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic sys_rst;
  logic start;
  logic cpu_hold, load_done, load_err;

  prog_loader_if #(.ADDR_W(4)) bus ();

  prog_loader #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk       (clk),
    .sys_rst   (sys_rst),
    .start     (start),
    .bus       (bus.slave),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  wr_t         exp_q[$];
  logic [31:0] tb_mem[16];
  logic [31:0] model_mem[16];
  logic [3:0]  exp_hold_addr = '0;
  logic [31:0] exp_hold_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write must be the next predicted one; the port holds otherwise.
  always @(negedge clk) begin
    if (sys_rst) begin
      exp_hold_addr = '0;
      exp_hold_data = '0;
      check("we_in_reset", bus.mem_we, 1'b0);
    end else if (bus.mem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", 1'b1, 1'b0);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr_addr", bus.mem_addr, w.addr);
        check("wr_data", bus.mem_wdata, w.data);
        exp_hold_addr = w.addr;
        exp_hold_data = w.data;
      end
      tb_mem[bus.mem_addr] = bus.mem_wdata;
    end else begin
      check("hold_addr", bus.mem_addr, exp_hold_addr);
      check("hold_data", bus.mem_wdata, exp_hold_data);
    end
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int budget;
    if (gaps) begin
      int k;
      k = $urandom_range(0, 3);
      repeat (k) @(negedge clk);
    end
    @(negedge clk);
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    budget = 0;
    while (!bus.byte_ready && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    if (budget >= 20) check("ready_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
    bus.byte_in    = 8'($urandom);
  endtask

  task automatic check_mem(input string name);
    for (int i = 0; i < 16; i++) check(name, tb_mem[i], model_mem[i]);
  endtask

  // One complete session: predict writes and outcome from the load format alone.
  task automatic run_session(input logic [7:0] hdr, input byte_q_t data,
                             input logic [7:0] csum, input bit gaps);
    logic [7:0] x;
    bit         good_hdr, exp_done;
    good_hdr = (hdr != 0) && (hdr <= 16);
    x = 8'h00;
    if (good_hdr) begin
      for (int w = 0; w < int'(hdr); w++) begin
        wr_t e;
        e.addr = 4'(w);
        e.data = {data[4*w], data[4*w+1], data[4*w+2], data[4*w+3]};
        exp_q.push_back(e);
        model_mem[w] = e.data;
        for (int j = 0; j < 4; j++) x ^= data[4*w+j];
      end
    end
    exp_done = good_hdr && (csum == x);

    pulse_start();
    check("hdr_done_clr", load_done, 1'b0);
    check("hdr_err_clr", load_err, 1'b0);
    check("hdr_ready", bus.byte_ready, 1'b1);
    send_byte(hdr, gaps);
    if (good_hdr) begin
      for (int i = 0; i < 4 * int'(hdr); i++) send_byte(data[i], gaps);
      send_byte(csum, gaps);
    end
    repeat (2) @(negedge clk);
    check("load_done", load_done, exp_done);
    check("load_err", load_err, !exp_done);
    check("cpu_hold", cpu_hold, !exp_done);
    check("ready_end", bus.byte_ready, 1'b0);
    check("writes_pending", exp_q.size(), 0);
    check_mem("mem");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    byte_q_t d;
    logic [7:0] x;
    for (int i = 0; i < 16; i++) begin
      tb_mem[i]    = '0;
      model_mem[i] = '0;
    end
    sys_rst        = 1'b1;
    start          = 1'b0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;

    // Reset values
    #1;
    check("rst_ready", bus.byte_ready, 1'b0);
    check("rst_we", bus.mem_we, 1'b0);
    check("rst_addr", bus.mem_addr, 4'h0);
    check("rst_wdata", bus.mem_wdata, 32'h0);
    check("rst_done", load_done, 1'b0);
    check("rst_err", load_err, 1'b0);
    check("rst_hold", cpu_hold, 1'b1);
    repeat (3) @(negedge clk);
    sys_rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_ready", bus.byte_ready, 1'b0);
    check("idle_hold", cpu_hold, 1'b1);

    // Two-word good load
    d = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_session(8'h02, d, 8'h88, 1'b0);
    check("lit_w0", tb_mem[0], 32'h11223344);
    check("lit_w1", tb_mem[1], 32'h55667788);
    check("lit_done", load_done, 1'b1);

    // Same data, bad checksum
    run_session(8'h02, d, 8'h00, 1'b0);
    check("lit_err", load_err, 1'b1);
    check("lit_err_hold", cpu_hold, 1'b1);

    // Bad headers, then recovery
    d = {};
    run_session(8'h00, d, 8'h00, 1'b0);
    run_session(8'h11, d, 8'h00, 1'b0);
    d = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_session(8'h01, d, 8'h04, 1'b0);

    // Single word with random back-pressure
    d = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    run_session(8'h01, d, 8'h22, 1'b1);
    check("lit_deadbeef", tb_mem[0], 32'hDEADBEEF);
    check("lit_deadbeef_done", load_done, 1'b1);

    // Full memory, then a one-word overwrite of address 0 only
    d = {};
    x = 8'h00;
    for (int i = 0; i < 64; i++) begin
      d.push_back(8'($urandom));
      x ^= d[i];
    end
    run_session(8'h10, d, x, 1'b1);
    d = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    run_session(8'h01, d, 8'h04, 1'b0);
    check("lit_overwrite", tb_mem[0], 32'hA1B2C3D4);

    // Reset mid-word, asserted between clock edges
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'hC0, 1'b0);
    send_byte(8'hFF, 1'b0);
    @(posedge clk);
    #2 sys_rst = 1'b1;
    #1;
    check("arst_ready", bus.byte_ready, 1'b0);
    check("arst_we", bus.mem_we, 1'b0);
    check("arst_addr", bus.mem_addr, 4'h0);
    check("arst_wdata", bus.mem_wdata, 32'h0);
    check("arst_done", load_done, 1'b0);
    check("arst_err", load_err, 1'b0);
    check("arst_hold", cpu_hold, 1'b1);
    repeat (2) @(negedge clk);
    sys_rst = 1'b0;
    bus.byte_in    = 8'h5A;
    bus.byte_valid = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_ready", bus.byte_ready, 1'b0);
    check("post_rst_hold", cpu_hold, 1'b1);
    check("post_rst_done", load_done, 1'b0);
    bus.byte_valid = 1'b0;
    check_mem("mem_after_rst");

    // Still loads normally afterwards
    d = '{8'h10, 8'h20, 8'h30, 8'h40};
    run_session(8'h01, d, 8'h40, 1'b0);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter DEPTH, default 16, number of 32-bit instruction-memory words.
REQ-002 Parameter ADDR_W, default 4, instruction-memory address width (log2 DEPTH).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 sys_rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  single-cycle request to begin a load session.
REQ-006 byte_in  input  8  serial program byte.
REQ-007 byte_valid  input  1  byte_in is valid this cycle.
REQ-008 byte_ready  output  1  loader accepts byte_in this cycle.
REQ-009 mem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 mem_addr  output  ADDR_W  instruction-memory word address.
REQ-011 mem_wdata  output  32  assembled instruction word.
REQ-012 cpu_hold  output  1  holds the processor in reset while high.
REQ-013 load_done  output  1  load completed with a good checksum (sticky).
REQ-014 load_err  output  1  load aborted on a bad header or bad checksum (sticky).

Function
REQ-015 A byte transfer occurs only on a cycle where byte_valid and byte_ready are both 1; no byte is consumed otherwise.
REQ-016 States: IDLE, HDR, DATA, WRITE, CSUM, DONE, ERR.
REQ-017 IDLE, DONE and ERR go to HDR on start=1; start is ignored in HDR, DATA, WRITE and CSUM.
REQ-018 Entering HDR clears load_done, load_err, the word index, the byte counter and the running XOR.
REQ-019 byte_ready is 1 in HDR, DATA and CSUM only; it is 0 in every other state.
REQ-020 HDR: the accepted byte is N, the word count; N in 1..DEPTH is latched and the block goes to DATA; N=0 or N>DEPTH goes to ERR.
REQ-021 DATA: accepted bytes are shifted in MSB-first, byte 0 going to [31:24]; each byte is XORed into the running checksum; after the 4th byte the block goes to WRITE.
REQ-022 WRITE lasts exactly one cycle: mem_we=1, mem_addr=word index, mem_wdata=assembled word.
REQ-023 From WRITE, if word index = N-1 the block goes to CSUM; otherwise the word index increments and the block returns to DATA with the byte counter at 0.
REQ-024 Latency from acceptance of a word's 4th byte to mem_we=1 is 1 cycle.
REQ-025 mem_we is 0 in every state other than WRITE; mem_addr and mem_wdata hold their last values outside WRITE.
REQ-026 CSUM: an accepted byte equal to the running XOR of all 4N data bytes goes to DONE; any other value goes to ERR. The header byte is not included in the XOR.
REQ-027 DONE: load_done=1 and cpu_hold=0. ERR: load_err=1 and cpu_hold=1.
REQ-028 cpu_hold is 1 in every state except DONE.
REQ-029 Words beyond N are never written, and the memory contents they hold are unchanged.
REQ-030 Back-pressure: byte_valid held at 0 for any number of cycles stalls the state machine with no state change.

Reset
REQ-031 sys_rst=1 immediately forces IDLE, independent of clk.
REQ-032 Reset values: byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, load_done=0, load_err=0, cpu_hold=1; word index, byte counter, N and XOR all 0.
REQ-033 Reset asserted mid-session abandons the partial word; no mem_we occurs after reset asserts.
REQ-034 After reset deasserts the block waits in IDLE until a start pulse.

Structure
REQ-035 A shared package holds the state enumeration, DEPTH and ADDR_W defaults, the byte-lane width (8) and the word width (32).
REQ-036 Byte-to-word assembly and the running XOR live in one sub-module, word_assembler: byte in, shift enable and clear in; 32-bit word and 8-bit XOR out.
REQ-037 The memory write port is kept outside this block; it connects to the processor's instruction memory write side.

Verification
REQ-038 Reset, start, header 0x02, bytes 11 22 33 44 55 66 77 88, checksum 0x88 -> mem_we at addr 0 with data 0x11223344, then addr 1 with data 0x55667788; load_done=1; cpu_hold=0.
REQ-039 Same as REQ-038 but checksum 0x00 -> both words written, load_err=1, load_done=0, cpu_hold=1.
REQ-040 Header 0x00, and separately header 0x11 -> ERR with no mem_we pulses; a following start and a good load reach DONE.
REQ-041 Header 0x01 with byte_valid toggling at random between bytes DE AD BE EF, checksum 0x22 -> single write of 0xDEADBEEF to addr 0; no duplicated or lost bytes.
REQ-042 Header 0x10 with 64 bytes plus the correct checksum -> 16 writes to addr 0..15 in order; then a start pulse with header 0x01 clears load_done and overwrites addr 0 only.
REQ-043 sys_rst asserted after the 2nd data byte, mid-clock -> outputs reach reset values asynchronously, no mem_we, state IDLE.
